// File: rtl/ofifo_skew.sv
// rtl/ofifo_skew.sv - output FIFO that aligns skewed per-column psums into complete rows
module ofifo_skew #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int DEPTH   = 64,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COL*PSUM_BW-1:0] in,
  input  logic [COL-1:0]         wr_col,
  input  logic                   wr_skew,
  input  logic                   rd,
  input  logic                   relu_en,
  input  logic                   clr_err,
  output logic [COL*PSUM_BW-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic [AW:0]            o_count,
  output logic                   o_err_ovf,
  output logic                   o_err_udf
);

  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - COL);

  logic [PSUM_BW-1:0] mem [COL][DEPTH];
  logic [AW-1:0]      wr_ptr [COL];
  logic [AW:0]        cnt [COL];
  logic [AW-1:0]      rd_ptr;
  logic [COL-2:0]     skew_sr;

  logic [COL-1:0]     skew_en;
  logic [COL-1:0]     we;
  logic [COL-1:0]     wacc;
  logic               rd_acc;
  logic               ovf_set;
  logic               udf_set;
  logic [AW:0]        min_cnt;

  // Per-column write enables, acceptance decisions and occupancy summaries.
  always_comb begin
    skew_en    = '0;
    skew_en[0] = wr_skew;
    for (int i = 1; i < COL; i++) skew_en[i] = skew_sr[i-1];
    we      = wr_col | skew_en;
    o_valid = 1'b1;
    o_full  = 1'b0;
    o_ready = 1'b1;
    min_cnt = cnt[0];
    for (int i = 0; i < COL; i++) begin
      if (cnt[i] == '0) o_valid = 1'b0;
      if (cnt[i] == DEPTH_C) o_full = 1'b1;
      if (cnt[i] > READY_MAX) o_ready = 1'b0;
      if (cnt[i] < min_cnt) min_cnt = cnt[i];
    end
    rd_acc  = rd & o_valid;
    udf_set = rd & ~o_valid;
    wacc    = '0;
    ovf_set = 1'b0;
    for (int i = 0; i < COL; i++) begin
      wacc[i] = we[i] & ((cnt[i] != DEPTH_C) | rd_acc);
      if (we[i] && !wacc[i]) ovf_set = 1'b1;
    end
    o_count = min_cnt;
  end

  // Head row presentation with optional ReLU clamp; stored data is untouched.
  always_comb begin
    out = '0;
    for (int i = 0; i < COL; i++) begin
      if (o_valid && !(relu_en && mem[i][rd_ptr][PSUM_BW-1]))
        out[i*PSUM_BW +: PSUM_BW] = mem[i][rd_ptr];
    end
  end

  // Column storage; contents survive reset, writes in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < COL; i++) begin
      if (!reset && wacc[i]) mem[i][wr_ptr[i]] <= in[i*PSUM_BW +: PSUM_BW];
    end
  end

  // Pointers, counts and the skew delay line.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      skew_sr <= '0;
      for (int i = 0; i < COL; i++) begin
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      skew_sr[0] <= wr_skew;
      for (int k = 1; k < COL-1; k++) skew_sr[k] <= skew_sr[k-1];
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      for (int i = 0; i < COL; i++) begin
        if (wacc[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        cnt[i] <= cnt[i] + (AW+1)'(wacc[i]) - (AW+1)'(rd_acc);
      end
    end
  end

  // Sticky error flags: setting wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_err_ovf <= 1'b0;
      o_err_udf <= 1'b0;
    end else begin
      if (ovf_set) o_err_ovf <= 1'b1;
      else if (clr_err) o_err_ovf <= 1'b0;
      if (udf_set) o_err_udf <= 1'b1;
      else if (clr_err) o_err_udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofifo_skew.sv
// tb/tb_ofifo_skew.sv - randomized scoreboard bench for ofifo_skew
module tb_ofifo_skew;
  localparam int COL = 8, PSUM_BW = 16, DEPTH = 64, AW = 6, W = COL*PSUM_BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, wr_skew, rd, relu_en, clr_err;
  logic [W-1:0] in;
  logic [COL-1:0] wr_col;
  logic [W-1:0] out;
  logic o_valid, o_full, o_ready, o_err_ovf, o_err_udf;
  logic [AW:0] o_count;

  ofifo_skew #(.COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in(in), .wr_col(wr_col), .wr_skew(wr_skew),
    .rd(rd), .relu_en(relu_en), .clr_err(clr_err), .out(out),
    .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_count(o_count),
    .o_err_ovf(o_err_ovf), .o_err_udf(o_err_udf)
  );

  int checks = 0, errors = 0;

  // Reference: one queue of values per column, history of recent skew strobes.
  logic [PSUM_BW-1:0] mq [COL][$];
  bit hist[$];
  bit m_ovf, m_udf;

  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_valid();
    for (int i = 0; i < COL; i++) if (mq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_min();
    int m = mq[0].size();
    for (int i = 1; i < COL; i++) if (mq[i].size() < m) m = mq[i].size();
    return m;
  endfunction

  task automatic model_step();
    bit valid, racc, ovf_set, udf_set, we;
    bit acc [COL];
    if (reset) begin
      for (int i = 0; i < COL; i++) mq[i].delete();
      hist.delete();
      m_ovf = 0;
      m_udf = 0;
      return;
    end
    valid   = m_valid();
    racc    = rd && valid;
    udf_set = rd && !valid;
    ovf_set = 0;
    for (int i = 0; i < COL; i++) begin
      we = wr_col[i] || (i == 0 ? wr_skew : (hist.size() >= i ? hist[i-1] : 1'b0));
      acc[i] = we && (mq[i].size() < DEPTH || racc);
      if (we && !acc[i]) ovf_set = 1;
    end
    for (int i = 0; i < COL; i++) begin
      if (racc) void'(mq[i].pop_front());
      if (acc[i]) mq[i].push_back(in[i*PSUM_BW +: PSUM_BW]);
    end
    if (ovf_set) m_ovf = 1; else if (clr_err) m_ovf = 0;
    if (udf_set) m_udf = 1; else if (clr_err) m_udf = 0;
    hist.push_front(wr_skew);
    if (hist.size() > COL-1) void'(hist.pop_back());
  endtask

  task automatic check_all(string tag);
    logic [W-1:0] exp_out;
    int mn;
    bit full, ready;
    exp_out = '0;
    full = 0;
    ready = 1;
    for (int i = 0; i < COL; i++) begin
      if (mq[i].size() == DEPTH) full = 1;
      if (mq[i].size() > DEPTH - COL) ready = 0;
    end
    if (m_valid())
      for (int i = 0; i < COL; i++)
        if (!(relu_en && mq[i][0][PSUM_BW-1])) exp_out[i*PSUM_BW +: PSUM_BW] = mq[i][0];
    mn = m_min();
    check({tag, ".out"}, out, exp_out);
    check({tag, ".valid"}, W'(o_valid), W'(m_valid()));
    check({tag, ".count"}, W'(o_count), W'(mn));
    check({tag, ".full"}, W'(o_full), W'(full));
    check({tag, ".ready"}, W'(o_ready), W'(ready));
    check({tag, ".ovf"}, W'(o_err_ovf), W'(m_ovf));
    check({tag, ".udf"}, W'(o_err_udf), W'(m_udf));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    wr_col = '0; wr_skew = 0; rd = 0; clr_err = 0; reset = 0;
  endtask

  logic [W-1:0] row_exp;

  initial begin
    idle();
    relu_en = 0;
    in = '0;
    reset = 1;
    tick("rst");
    tick("rst");
    check("rst_out", out, '0);
    check("rst_ready", W'(o_ready), W'(1));
    check("rst_count", W'(o_count), W'(0));
    reset = 0;

    // single skewed row, column i = i+1
    for (int i = 0; i < COL; i++) in[i*PSUM_BW +: PSUM_BW] = PSUM_BW'(i+1);
    row_exp = in;
    wr_skew = 1;
    tick("skew0");
    wr_skew = 0;
    for (int k = 0; k < COL-2; k++) begin
      tick("skew_wait");
      check("skew_not_yet", W'(o_valid), W'(0));
    end
    tick("skew_done");
    check("skew_valid", W'(o_valid), W'(1));
    check("skew_row", out, row_exp);
    rd = 1;
    tick("skew_pop");
    rd = 0;
    check("skew_empty", W'(o_count), W'(0));

    // fill to DEPTH rows via back-to-back skew
    for (int k = 0; k < DEPTH; k++) begin
      in = {$urandom, $urandom, $urandom, $urandom};
      wr_skew = 1;
      tick("fill");
    end
    wr_skew = 0;
    for (int k = 0; k < COL-1; k++) begin
      in = {$urandom, $urandom, $urandom, $urandom};
      tick("fill_tail");
    end
    check("fill_count", W'(o_count), W'(DEPTH));
    check("fill_full", W'(o_full), W'(1));
    check("fill_noovf", W'(o_err_ovf), W'(0));

    // write while full: dropped; then with simultaneous read: accepted
    wr_col = '1;
    in = '1;
    tick("ovf");
    check("ovf_flag", W'(o_err_ovf), W'(1));
    check("ovf_count", W'(o_count), W'(DEPTH));
    wr_col = '0;
    clr_err = 1;
    tick("ovf_clr");
    clr_err = 0;
    wr_col = '1;
    rd = 1;
    tick("full_rdwr");
    check("rdwr_noovf", W'(o_err_ovf), W'(0));
    check("rdwr_count", W'(o_count), W'(DEPTH));
    wr_col = '0;
    for (int k = 0; k < DEPTH; k++) tick("drain");

    // underflow and sticky-flag priority
    tick("udf");
    check("udf_flag", W'(o_err_udf), W'(1));
    check("udf_count", W'(o_count), W'(0));
    rd = 0;
    clr_err = 1;
    tick("udf_clr");
    check("udf_cleared", W'(o_err_udf), W'(0));
    rd = 1;
    tick("udf_clr_set");
    check("udf_set_wins", W'(o_err_udf), W'(1));
    rd = 0;
    tick("udf_clr2");
    clr_err = 0;

    // ReLU on the read path only
    in = '0;
    in[0 +: PSUM_BW] = -16'sd5;
    in[PSUM_BW +: PSUM_BW] = 16'sd7;
    wr_col = '1;
    tick("relu_wr");
    wr_col = '0;
    relu_en = 1;
    #1;
    check("relu_c0", W'(out[0 +: PSUM_BW]), W'(0));
    check("relu_c1", W'(out[PSUM_BW +: PSUM_BW]), W'(7));
    relu_en = 0;
    #1;
    check("norelu_c0", W'(out[0 +: PSUM_BW]), W'(16'hFFFB));
    check("norelu_c1", W'(out[PSUM_BW +: PSUM_BW]), W'(7));
    rd = 1;
    tick("relu_pop");
    rd = 0;

    // randomized mixing with a reset in the middle
    for (int k = 0; k < 2400; k++) begin
      in = {$urandom, $urandom, $urandom, $urandom};
      wr_skew = ($urandom_range(0, 99) < 25);
      for (int i = 0; i < COL; i++) wr_col[i] = ($urandom_range(0, 99) < 15);
      rd = ($urandom_range(0, 99) < 40);
      relu_en = ($urandom_range(0, 99) < 30);
      clr_err = ($urandom_range(0, 99) < 5);
      reset = (k == 1200);
      tick("rand");
      if (k == 1200) begin
        check("midrst_count", W'(o_count), W'(0));
        check("midrst_valid", W'(o_valid), W'(0));
        check("midrst_ovf", W'(o_err_ovf), W'(0));
      end
    end
    idle();
    for (int k = 0; k < COL; k++) tick("settle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ofifo_skew.md
# ofifo_skew

Parametrised output FIFO between the systolic PE array and the output SRAM / SFP stage. It captures per-column partial sums arriving at different cycles, either through independent per-column strobes or through a single skewed write strobe delayed internally by one cycle per column. It releases data only as complete, column-aligned rows, with optional ReLU on the read path. It adds occupancy reporting, almost-full back-pressure sized for in-flight skewed writes, and sticky overflow/underflow error flags.

## Interface
- COL, 8, number of columns (≥2)
- PSUM_BW, 16, signed partial-sum width per column
- DEPTH, 64, entries per column; power of two, ≥ 2*COL
- AW, log2(DEPTH), derived, not overridden

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in  in  COL*PSUM_BW  column data; column i at bits [(i+1)*PSUM_BW-1 : i*PSUM_BW]
- wr_col  in  COL  direct per-column write strobes
- wr_skew  in  1  skewed row write; column i written i cycles later
- rd  in  1  pop one complete row
- relu_en  in  1  clamp negative outputs to 0
- clr_err  in  1  clear sticky error flags
- out  out  COL*PSUM_BW  head row (FWFT), same column packing as in
- o_valid  out  1  at least one complete row available
- o_full  out  1  any column holds DEPTH entries
- o_ready  out  1  every column count ≤ DEPTH-COL
- o_count  out  AW+1  complete rows available (minimum column count)
- o_err_ovf  out  1  sticky: a write was dropped
- o_err_udf  out  1  sticky: rd asserted with o_valid low

## Operation
- Per column: circular buffer of DEPTH×PSUM_BW, write pointer, count (AW+1 bits). Single read pointer shared by all columns.
- Skew line: COL-1 bit shift register. skew_en[0] = wr_skew (current cycle). skew_en[i] = wr_skew delayed by i cycles. The shift register shifts every cycle, inserting wr_skew.
- Effective write for column i: we[i] = wr_col[i] | skew_en[i]. If both are set, exactly one entry is written. Data is in slice i sampled in the cycle we[i] is high.
- Write acceptance: accepted if count[i] < DEPTH, or if count[i] == DEPTH and a read is accepted in the same cycle. Otherwise the write is dropped, the column is unchanged, and o_err_ovf is set.
- Read acceptance: rd & o_valid pops one entry from every column and advances the read pointer (wraps DEPTH-1 → 0). rd with o_valid low changes no state and sets o_err_udf.
- Simultaneous accepted read and write on a column: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Counts saturate at neither end, because acceptance rules prevent overflow and underflow.
- out column i = mem_i[rd_ptr] when o_valid, else 0. With relu_en=1, negative values (MSB=1) read as 0. relu_en affects the output only, never stored data.
- o_valid = all counts ≥ 1. o_count = min over columns of count. o_full = OR over columns of (count == DEPTH). o_ready = all counts ≤ DEPTH-COL, which guarantees room for up to COL-1 in-flight skewed writes plus one new row.
- Error flags: reset has priority, then set, then clr_err. If set and clr_err occur in the same cycle, the flag stays set.

## Timing
- Reset: all counts, pointers, skew register, and error flags are 0. Outputs: out=0, o_valid=0, o_full=0, o_ready=1, o_count=0, o_err_ovf=0, o_err_udf=0. Memory contents are not reset.
- Reset mid-operation discards in-flight skewed writes. Writes and reads in the reset cycle are ignored.
- Write to read latency: a row completed by a write at edge t shows o_valid=1 and the data on out after edge t. The earliest row read is the cycle after the last column write.
- Skewed row issued at cycle t: column i is written at edge t+i. o_valid rises after edge t+COL-1.
- Read is FWFT: out shows the head row combinationally. After an accepted rd at edge t, the next row (or 0) appears after edge t.
- o_count, o_full, o_ready, and o_valid derive from registered counts and have no combinational path from inputs. out depends combinationally only on relu_en and state.

## Test plan
- Reset, then wr_skew=1 for one cycle with column i = i+1: o_valid rises exactly COL-1 cycles after the strobe edge; out = {8,7,...,1}; rd pops; o_count returns to 0.
- Back-to-back wr_skew for DEPTH-COL+1 cycles with rd=0: o_ready falls when any count exceeds DEPTH-COL. Continuing to DEPTH rows gives o_full=1, o_count=DEPTH, and no o_err_ovf.
- One extra wr_col=all-ones while full, no rd: o_err_ovf=1, o_count stays DEPTH, data intact. Repeat with rd=1 in the same cycle: the write is accepted, count stays DEPTH, and no new error.
- rd with o_valid=0: o_err_udf=1, state unchanged. clr_err clears it. clr_err plus a new underflow in the same cycle leaves the flag at 1.
- Store column values -5 and 7. With relu_en=1 out shows 0 and 7; with relu_en=0 it shows -5 and 7 (16'hFFFB).
- Write 3·DEPTH rows with interleaved reads and random wr_col/wr_skew mixing, including a reset mid-burst: output order matches a scoreboard, pointers wrap correctly, and all state is 0 after reset.
